control_sincronizacion: RTL and testbench

CONTROL_SINCRONIZACION -- requirements
Module: control_sincronizacion

---
 rtl/control_sincronizacion.sv | 136 +++++++++++++
 tb/tb_control_sincronizacion.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/control_sincronizacion.sv
// Comma-based byte alignment and lock controller.
// Hunts for 0xBC comma bytes in the deserializer output, requests one-bit
// slips while misaligned, declares lock after LOCK_COUNT consecutive commas,
// then forwards non-comma payload bytes until too many arrive without a comma.
module control_sincronizacion #(
   parameter int LOCK_COUNT = 4,
   parameter int SLIP_WAIT  = 8,
   parameter int MAX_GAP    = 32
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       byte_strobe,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       bit_slip,
   output logic       active,
   output logic       sync_lost,
   output logic [1:0] state
);

   localparam int LW = $clog2(LOCK_COUNT + 1);
   localparam int SW = $clog2(SLIP_WAIT + 1);
   localparam int GW = $clog2(MAX_GAP + 1);

   localparam logic [1:0] ST_RESET   = 2'd0;
   localparam logic [1:0] ST_SEARCH  = 2'd1;
   localparam logic [1:0] ST_LOCKING = 2'd2;
   localparam logic [1:0] ST_ACTIVE  = 2'd3;

   localparam logic [7:0] COMMA = 8'hBC;

   logic [LW-1:0] lock_cnt, lock_n;
   logic [SW-1:0] settle_cnt, settle_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [1:0]    state_n;
   logic [7:0]    data_n;
   logic          valid_n, slip_n, lost_n;
   logic          is_comma;

   assign is_comma = (byte_in == COMMA);

   // Next-state and next-output decision; only strobes outside the settle
   // window reach the FSM, the others just drain the settle counter.
   always_comb begin
      state_n  = state;
      lock_n   = lock_cnt;
      settle_n = settle_cnt;
      gap_n    = gap_cnt;
      data_n   = data_out;
      valid_n  = 1'b0;
      slip_n   = 1'b0;
      lost_n   = 1'b0;
      if (state == ST_RESET) begin
         // A strobe coinciding with the first edge out of reset is dropped.
         state_n = ST_SEARCH;
      end else if (byte_strobe && (settle_cnt != '0)) begin
         settle_n = settle_cnt - 1'b1;
      end else if (byte_strobe) begin
         case (state)
            ST_SEARCH: begin
               if (is_comma) begin
                  if (LOCK_COUNT <= 1) begin
                     state_n = ST_ACTIVE;
                     lock_n  = '0;
                     gap_n   = '0;
                  end else begin
                     state_n = ST_LOCKING;
                     lock_n  = LW'(1);
                  end
               end else begin
                  slip_n   = 1'b1;
                  settle_n = SW'(SLIP_WAIT);
               end
            end
            ST_LOCKING: begin
               if (is_comma) begin
                  if (int'(lock_cnt) + 1 >= LOCK_COUNT) begin
                     state_n = ST_ACTIVE;
                     lock_n  = '0;
                     gap_n   = '0;
                  end else begin
                     lock_n = lock_cnt + 1'b1;
                  end
               end else begin
                  state_n  = ST_SEARCH;
                  lock_n   = '0;
                  slip_n   = 1'b1;
                  settle_n = SW'(SLIP_WAIT);
               end
            end
            ST_ACTIVE: begin
               if (is_comma) begin
                  gap_n = '0;
               end else if (gap_cnt == GW'(MAX_GAP - 1)) begin
                  // Too long without a comma: alignment is presumed lost.
                  state_n = ST_SEARCH;
                  gap_n   = '0;
                  lost_n  = 1'b1;
               end else begin
                  data_n  = byte_in;
                  valid_n = 1'b1;
                  gap_n   = gap_cnt + 1'b1;
               end
            end
            default: state_n = ST_RESET;
         endcase
      end
   end

   // Register every output and counter; reset clears everything at once.
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state      <= ST_RESET;
         lock_cnt   <= '0;
         settle_cnt <= '0;
         gap_cnt    <= '0;
         data_out   <= 8'h00;
         valid_out  <= 1'b0;
         bit_slip   <= 1'b0;
         sync_lost  <= 1'b0;
         active     <= 1'b0;
      end else begin
         state      <= state_n;
         lock_cnt   <= lock_n;
         settle_cnt <= settle_n;
         gap_cnt    <= gap_n;
         data_out   <= data_n;
         valid_out  <= valid_n;
         bit_slip   <= slip_n;
         sync_lost  <= lost_n;
         active     <= (state_n == ST_ACTIVE);
      end
   end

endmodule

// File: tb/tb_control_sincronizacion.sv
// Testbench for control_sincronizacion: directed scenarios followed by random
// traffic, every cycle compared against a strobe-level reference model.
module tb_control_sincronizacion;

   localparam int LOCK_COUNT = 4;
   localparam int SLIP_WAIT  = 8;
   localparam int MAX_GAP    = 32;

   logic       clk_4f = 1'b0;
   logic       reset;
   logic [7:0] byte_in;
   logic       byte_strobe;
   logic [7:0] data_out;
   logic       valid_out, bit_slip, active, sync_lost;
   logic [1:0] state;

   control_sincronizacion #(
      .LOCK_COUNT(LOCK_COUNT), .SLIP_WAIT(SLIP_WAIT), .MAX_GAP(MAX_GAP)
   ) dut (
      .clk_4f(clk_4f), .reset(reset), .byte_in(byte_in), .byte_strobe(byte_strobe),
      .data_out(data_out), .valid_out(valid_out), .bit_slip(bit_slip),
      .active(active), .sync_lost(sync_lost), .state(state)
   );

   always #5 clk_4f = ~clk_4f;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: phase (0 reset,1 search,2 locking,3 active), comma run
   // length, strobes still to skip, payload bytes since last comma.
   int         m_phase, m_run, m_skip, m_gap;
   logic [7:0] m_data;
   logic       e_valid, e_slip, e_lost;
   int         n_valid, n_slip, n_lost;

   function automatic void model_reset();
      m_phase = 0; m_run = 0; m_skip = 0; m_gap = 0; m_data = 8'h00;
      e_valid = 0; e_slip = 0; e_lost = 0;
   endfunction

   function automatic void model_step(input logic s, input logic [7:0] b);
      e_valid = 0; e_slip = 0; e_lost = 0;
      if (m_phase == 0) begin m_phase = 1; return; end
      if (!s) return;
      if (m_skip > 0) begin m_skip--; return; end
      if (m_phase == 1) begin
         if (b == 8'hBC) begin m_run = 1; m_phase = (m_run >= LOCK_COUNT) ? 3 : 2; m_gap = 0; end
         else begin e_slip = 1; m_skip = SLIP_WAIT; end
      end else if (m_phase == 2) begin
         if (b == 8'hBC) begin
            m_run++;
            if (m_run >= LOCK_COUNT) begin m_phase = 3; m_gap = 0; end
         end else begin m_run = 0; e_slip = 1; m_skip = SLIP_WAIT; m_phase = 1; end
      end else begin
         if (b == 8'hBC) m_gap = 0;
         else if (m_gap + 1 >= MAX_GAP) begin m_phase = 1; m_gap = 0; e_lost = 1; end
         else begin m_data = b; e_valid = 1; m_gap++; end
      end
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("state",     {6'd0, state},     8'(m_phase));
      chk("data_out",  data_out,          m_data);
      chk("valid_out", {7'd0, valid_out}, {7'd0, e_valid});
      chk("bit_slip",  {7'd0, bit_slip},  {7'd0, e_slip});
      chk("active",    {7'd0, active},    {7'd0, (m_phase == 3)});
      chk("sync_lost", {7'd0, sync_lost}, {7'd0, e_lost});
      if (valid_out) n_valid++;
      if (bit_slip)  n_slip++;
      if (sync_lost) n_lost++;
   endtask

   // One clock: drive at the falling edge, model at the rising edge, compare
   // at the next falling edge.
   task automatic cyc(input logic s, input logic [7:0] b);
      byte_strobe = s; byte_in = b;
      @(posedge clk_4f);
      model_step(s, b);
      @(negedge clk_4f);
      chk_all();
   endtask

   task automatic rep(input int n, input logic [7:0] b);
      for (int i = 0; i < n; i++) cyc(1'b1, b);
   endtask

   // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
   task automatic async_reset();
      #2 reset = 1'b1;
      #1 model_reset();
      chk_all();
      @(negedge clk_4f);
      byte_strobe = 1'b1; byte_in = 8'hBC;   // strobe on the release edge
      reset = 1'b0;
      @(posedge clk_4f);
      model_step(1'b1, 8'hBC);
      @(negedge clk_4f);
      chk_all();
   endtask

   task automatic clr_counts();
      n_valid = 0; n_slip = 0; n_lost = 0;
   endtask

   initial begin
      reset = 1'b1; byte_strobe = 1'b0; byte_in = 8'h00;
      model_reset(); clr_counts();
      @(negedge clk_4f);
      chk_all();
      @(negedge clk_4f);
      reset = 1'b0;
      cyc(1'b0, 8'h00);

      // Clean lock then two payload bytes.
      clr_counts();
      rep(4, 8'hBC);
      chk("lock_after_4", {7'd0, active}, 8'd1);
      cyc(1'b1, 8'hFF); chk("d_ff", data_out, 8'hFF);
      cyc(1'b1, 8'hEE); chk("d_ee", data_out, 8'hEE);
      chk("slips_031", 8'(n_slip), 8'd0);
      chk("valids_031", 8'(n_valid), 8'd2);

      // Misaligned byte, settle window, then lock.
      async_reset(); clr_counts();
      cyc(1'b1, 8'h5E);
      for (int i = 0; i < SLIP_WAIT; i++) cyc(1'b1, 8'(i == 3 ? 8'hBC : $urandom));
      rep(4, 8'hBC);
      chk("slips_032", 8'(n_slip), 8'd1);
      chk("active_032", {7'd0, active}, 8'd1);

      // Broken lock attempt.
      async_reset(); clr_counts();
      cyc(1'b1, 8'hBC); cyc(1'b1, 8'hBC); cyc(1'b1, 8'h12);
      chk("state_033", {6'd0, state}, 8'd1);
      chk("slips_033", 8'(n_slip), 8'd1);
      chk("valids_033", 8'(n_valid), 8'd0);

      // Gap overflow.
      async_reset(); rep(4, 8'hBC); clr_counts();
      rep(MAX_GAP, 8'hAA);
      chk("valids_034", 8'(n_valid), 8'(MAX_GAP - 1));
      chk("lost_034", 8'(n_lost), 8'd1);
      chk("state_034", {6'd0, state}, 8'd1);

      // Idle comma between payload, with strobe gaps.
      async_reset(); rep(4, 8'hBC); clr_counts();
      cyc(1'b1, 8'hAA); cyc(1'b0, 8'h00); cyc(1'b1, 8'hBC);
      chk("hold_035", data_out, 8'hAA);
      cyc(1'b0, 8'h33); cyc(1'b1, 8'hAA);
      chk("valids_035", 8'(n_valid), 8'd2);

      // Reset during ACTIVE and during a settle window, then relock.
      rep(3, 8'h41);
      clr_counts();
      async_reset();
      chk("lost_036", 8'(n_lost), 8'd0);
      rep(3, 8'hBC);
      chk("not_yet_036", {7'd0, active}, 8'd0);
      cyc(1'b1, 8'hBC);
      chk("relock_036", {7'd0, active}, 8'd1);
      async_reset();
      cyc(1'b1, 8'h00);
      cyc(1'b1, 8'h01);
      async_reset();
      rep(4, 8'hBC);

      // Random traffic: comma-rich, then comma-sparse to reach gap overflow.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] b;
         int pct;
         pct = (i < 1500) ? 50 : 3;
         b = ($urandom_range(99) < pct) ? 8'hBC : 8'($urandom);
         cyc(($urandom_range(3) != 0), b);
         if ($urandom_range(499) == 0) async_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
